// File: rtl/wb_ctrl_pkg.sv
// ============================================================================
// wb_ctrl_pkg
// Shared core definitions for the write-back path: RV32I opcode constants,
// rd write-data select encodings, write-back FSM state encodings and a small
// opcode decode helper. Imported by wb_ctrl, rd_mux and the decoder so every
// consumer agrees on the same encodings.
// ============================================================================
package wb_ctrl_pkg;

   // RV32I major opcodes (instruction bits [6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Select for the rd write-data mux
   typedef enum logic [1:0] {
      RD_SEL_IMM = 2'd0,
      RD_SEL_PC  = 2'd1,
      RD_SEL_ALU = 2'd2,
      RD_SEL_MEM = 2'd3
   } rd_sel_t;

   // Write-back controller states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_WB       = 2'd2
   } wb_state_t;

   // Everything the controller needs to know about an opcode
   typedef struct packed {
      logic    writes;
      logic    is_load;
      rd_sel_t rd_sel;
   } wb_decode_t;

   // Map an opcode to its write-back behaviour. Non-writing and unknown
   // opcodes still pass through WB, they just never raise the write strobe.
   function automatic wb_decode_t decode_opcode(input logic [6:0] op);
      wb_decode_t dec;
      dec.writes  = 1'b0;
      dec.is_load = 1'b0;
      dec.rd_sel  = RD_SEL_IMM;
      case (op)
         OPC_LUI: begin
            dec.writes = 1'b1;
            dec.rd_sel = RD_SEL_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            dec.writes = 1'b1;
            dec.rd_sel = RD_SEL_PC;
         end
         OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
            dec.writes = 1'b1;
            dec.rd_sel = RD_SEL_ALU;
         end
         OPC_LOAD: begin
            dec.writes  = 1'b1;
            dec.is_load = 1'b1;
            dec.rd_sel  = RD_SEL_MEM;
         end
         OPC_STORE, OPC_BRANCH, OPC_FENCE, OPC_SYSTEM: begin
            dec.writes = 1'b0;
         end
         default: begin
            dec.writes = 1'b0;
         end
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/wb_ctrl_timeout.sv
// ============================================================================
// wb_timeout
// Counts consecutive cycles spent waiting for load data. The count restarts
// whenever count_en drops, so each load gets a fresh budget.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   count_en : high while the controller sits in MEM_WAIT
//   expired  : high during the last allowed MEM_WAIT cycle
// ============================================================================
module wb_timeout
   import wb_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] count_q;

   // Counter holds the number of MEM_WAIT cycles already completed; it is
   // zero in the first MEM_WAIT cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (count_en) begin
         count_q <= count_q + 1'b1;
      end else begin
         count_q <= '0;
      end
   end

   // Expired during the TIMEOUT_CYCLES-th cycle, so the abort lands on the
   // edge that ends that cycle.
   assign expired = count_en && (count_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_ctrl.sv
// ============================================================================
// wb_ctrl
// Write-back controller: accepts one decoded instruction per cycle, waits for
// load data when needed, and drives the register-file write strobe, address
// and rd write-data select.
//
// Configuration
//   WB_TIMEOUT_EN : when defined, a load waiting TIMEOUT_CYCLES cycles without
//                   mem_ack is aborted (no write) and err pulses for a cycle.
//                   When undefined, loads wait forever and err is tied to 0.
//
// Ports
//   clk, rst             : clock (rising edge), async reset active low
//   instr_valid/ready    : instruction handshake
//   opcode, rd_addr      : fields of the presented instruction
//   mem_req, mem_ack     : load data request / data valid
//   rd_sel               : rd mux select (0 imm, 1 pc, 2 alu, 3 mem)
//   rf_wr_en, rf_wr_addr : register-file write port control
//   busy                 : instruction in flight
//   err                  : one-cycle pulse on load timeout
// ============================================================================
module wb_ctrl
   import wb_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [6:0] opcode,
   input  logic [4:0] rd_addr,
   output logic       mem_req,
   input  logic       mem_ack,
   output logic [1:0] rd_sel,
   output logic       rf_wr_en,
   output logic [4:0] rf_wr_addr,
   output logic       busy,
   output logic       err
);

   if (TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("wb_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   wb_state_t  state_q;
   wb_state_t  state_next;
   wb_decode_t dec;
   logic       accept;
   logic       timeout_abort;
   logic       writes_q;
   rd_sel_t    rd_sel_q;
   logic [4:0] rd_addr_q;

   assign dec    = decode_opcode(opcode);
   assign accept = instr_valid && instr_ready;

`ifdef WB_TIMEOUT_EN
   logic expired;
   logic err_q;

   wb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .count_en (state_q == ST_MEM_WAIT),
      .expired  (expired)
   );

   // mem_ack in the final cycle beats the timeout.
   assign timeout_abort = (state_q == ST_MEM_WAIT) && expired && !mem_ack;

   // err is registered so it pulses in the first IDLE cycle after the abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= timeout_abort;
      end
   end

   assign err = err_q;
`else
   assign timeout_abort = 1'b0;
   assign err           = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   // Latch the destination and decoded behaviour of each accepted
   // instruction; they stay put until the next accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         writes_q  <= 1'b0;
         rd_sel_q  <= RD_SEL_IMM;
         rd_addr_q <= 5'd0;
      end else if (accept) begin
         writes_q  <= dec.writes;
         rd_sel_q  <= dec.rd_sel;
         rd_addr_q <= rd_addr;
      end
   end

   // Next-state logic. IDLE and WB behave alike on accept, which is what
   // gives back-to-back throughput of one non-load per cycle.
   always_comb begin
      state_next = state_q;
      case (state_q)
         ST_IDLE, ST_WB: begin
            if (accept) begin
               state_next = dec.is_load ? ST_MEM_WAIT : ST_WB;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               state_next = ST_WB;
            end else if (timeout_abort) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic. Writes to x0 are dropped here rather than at decode so
   // rf_wr_addr still reflects the instruction for observability.
   always_comb begin
      instr_ready = 1'b1;
      mem_req     = 1'b0;
      rf_wr_en    = 1'b0;
      busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_MEM_WAIT: begin
            instr_ready = 1'b0;
            mem_req     = 1'b1;
         end
         ST_WB: begin
            rf_wr_en = writes_q && (rd_addr_q != 5'd0);
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign rd_sel     = rd_sel_q;
   assign rf_wr_addr = rd_addr_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// ============================================================================
// tb_wb_ctrl
// Self-checking bench for wb_ctrl. Expected register writes are queued when
// an instruction is driven and compared whenever the DUT raises rf_wr_en.
// Define WB_TIMEOUT_EN for both RTL and bench to include the timeout cases.
// ============================================================================
module tb_wb_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [6:0] opcode = 7'd0;
   logic [4:0] rd_addr = 5'd0;
   logic       mem_req;
   logic       mem_ack = 1'b0;
   logic [1:0] rd_sel;
   logic       rf_wr_en;
   logic [4:0] rf_wr_addr;
   logic       busy;
   logic       err;

   typedef struct packed {
      logic [4:0] addr;
      logic [1:0] sel;
   } exp_t;

   exp_t sb[$];
   int   writeCycles[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   writeCount = 0;
   int   savedWrites;

   wb_ctrl #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .rd_addr     (rd_addr),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .rd_sel      (rd_sel),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Reference model of which opcodes write and what they select
   function automatic bit modelWrites(input logic [6:0] op, output logic [1:0] sel);
      sel = 2'd0;
      case (op)
         7'b0110111: begin sel = 2'd0; return 1'b1; end
         7'b1101111,
         7'b1100111: begin sel = 2'd1; return 1'b1; end
         7'b0110011,
         7'b0010011,
         7'b0010111: begin sel = 2'd2; return 1'b1; end
         7'b0000011: begin sel = 2'd3; return 1'b1; end
         default:    return 1'b0;
      endcase
   endfunction

   // Present one instruction for exactly one rising edge; returns 1 time
   // unit after that edge.
   task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd);
      logic [1:0] s;
      exp_t       e;
      checkOutput("ready_at_issue", instr_ready, 1);
      opcode      = op;
      rd_addr     = rd;
      instr_valid = 1'b1;
      if (modelWrites(op, s) && rd != 5'd0) begin
         e.addr = rd;
         e.sel  = s;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   // Write monitor: every strobe must match the oldest expected write
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && rf_wr_en) begin
         writeCount++;
         writeCycles.push_back(cyc);
         if (sb.size() == 0) begin
            checkOutput("unexpected_wr", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("wr_addr", rf_wr_addr, e.addr);
            checkOutput("wr_sel", rd_sel, e.sel);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready", instr_ready, 1);
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_wr_en", rf_wr_en, 0);
      checkOutput("rst_rd_sel", rd_sel, 0);
      checkOutput("rst_wr_addr", rf_wr_addr, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Back-to-back LUI, OP, JAL
      writeCycles.delete();
      applyStimulus(7'b0110111, 5'd1);
      applyStimulus(7'b0110011, 5'd2);
      applyStimulus(7'b1101111, 5'd3);
      @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("b2b_count", writeCycles.size(), 3);
      if (writeCycles.size() == 3) begin
         checkOutput("b2b_consec1", writeCycles[1] - writeCycles[0], 1);
         checkOutput("b2b_consec2", writeCycles[2] - writeCycles[1], 1);
      end
      checkOutput("b2b_sb_empty", sb.size(), 0);
      checkOutput("b2b_idle", busy, 0);

      // Load rd=7, mem_ack in the third wait cycle; an instruction presented
      // during MEM_WAIT must be ignored.
      applyStimulus(7'b0000011, 5'd7);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checkOutput("ld_mem_req", mem_req, 1);
         checkOutput("ld_ready", instr_ready, 0);
         checkOutput("ld_no_wr", rf_wr_en, 0);
         if (i == 1) begin
            opcode      = 7'b0110111;
            rd_addr     = 5'd9;
            instr_valid = 1'b1;
         end
         if (i == 2) instr_valid = 1'b0;
         if (i == 3) mem_ack = 1'b1;
         @(posedge clk);
         #1;
      end
      mem_ack = 1'b0;
      @(negedge clk);
      checkOutput("ld_wb_wr_en", rf_wr_en, 1);
      checkOutput("ld_wb_mem_req", mem_req, 0);
      checkOutput("ld_wb_ready", instr_ready, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("ld_done_idle", busy, 0);
      @(posedge clk);
      #1;

      // x0 destination then STORE: WB twice, never a write
      applyStimulus(7'b0010011, 5'd0);
      @(negedge clk);
      checkOutput("x0_busy", busy, 1);
      checkOutput("x0_no_wr", rf_wr_en, 0);
      applyStimulus(7'b0100011, 5'd9);
      @(negedge clk);
      checkOutput("st_busy", busy, 1);
      checkOutput("st_no_wr", rf_wr_en, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("st_idle", busy, 0);

      // mem_ack outside MEM_WAIT is ignored
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      checkOutput("ack_idle_busy", busy, 0);
      checkOutput("ack_idle_wr", rf_wr_en, 0);
      @(posedge clk);
      #1;

      // Reset in the middle of a load abandons it
      savedWrites = writeCount;
      applyStimulus(7'b0000011, 5'd5);
      @(negedge clk);
      checkOutput("rl_mem_req", mem_req, 1);
      #2;
      rst = 1'b0;
      sb.delete();
      #1;
      checkOutput("rl_mem_req_off", mem_req, 0);
      checkOutput("rl_busy", busy, 0);
      checkOutput("rl_ready", instr_ready, 1);
      checkOutput("rl_wr_addr", rf_wr_addr, 0);
      checkOutput("rl_rd_sel", rd_sel, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rl_no_write", writeCount, savedWrites);
      @(posedge clk);
      #1;

`ifdef WB_TIMEOUT_EN
      // Load with no mem_ack: abort after 4 wait cycles
      savedWrites = writeCount;
      applyStimulus(7'b0000011, 5'd6);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checkOutput("to_mem_req", mem_req, 1);
         checkOutput("to_err_low", err, 0);
         @(posedge clk);
         #1;
      end
      void'(sb.pop_back());
      @(negedge clk);
      checkOutput("to_idle", busy, 0);
      checkOutput("to_err", err, 1);
      checkOutput("to_no_wr", rf_wr_en, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("to_err_pulse", err, 0);
      checkOutput("to_no_write", writeCount, savedWrites);
      @(posedge clk);
      #1;

      // mem_ack in the 4th wait cycle wins over the timeout
      applyStimulus(7'b0000011, 5'd6);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checkOutput("ta_mem_req", mem_req, 1);
         if (i == 4) mem_ack = 1'b1;
         @(posedge clk);
         #1;
      end
      mem_ack = 1'b0;
      @(negedge clk);
      checkOutput("ta_wr_en", rf_wr_en, 1);
      checkOutput("ta_err", err, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("ta_err_after", err, 0);
      @(posedge clk);
      #1;
`endif

      checkOutput("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
